// File: rtl/pedestrian_signal_controller.sv
`default_nettype none
// ============================================================================
// Module   : pedestrian_signal_controller
// Brief    : Pedestrian WALK / flashing DON'T-WALK sequencer slaved to the
//            vehicle light outputs; fails safe on any non-one-hot light pattern.
// Revision : 1.0 - initial release
// ============================================================================
module pedestrian_signal_controller #(
    parameter logic [3:0] WALK_TIME  = 4'd6,
    parameter logic [3:0] FLASH_TIME = 4'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_button,
    input  logic       red_light,
    input  logic       yellow_light,
    input  logic       green_light,
    output logic       walk,
    output logic       dont_walk,
    output logic       flash,
    output logic       ped_wait,
    output logic [3:0] countdown,
    output logic       fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_FLASH = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [3:0] c_WALK_LOAD  = WALK_TIME - 4'd1;
    localparam logic [3:0] c_FLASH_LOAD = FLASH_TIME - 4'd1;
    localparam logic [1:0] c_GUARD_DONE = 2'd2;

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic       r_sync1;
    logic       r_sync2;
    logic       r_btn_prev;
    logic       r_red_q;
    logic [1:0] r_guard;

    logic       w_btn_rise;
    logic       w_red_rise;
    logic       w_check_en;
    logic       w_lights_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_btn_prev <= 1'b0;
            r_red_q    <= 1'b0;
            r_guard    <= 2'd0;
        end else begin
            r_sync1    <= ped_button;
            r_sync2    <= r_sync1;
            r_btn_prev <= r_sync2;
            r_red_q    <= red_light;
            if (r_guard != c_GUARD_DONE) begin
                r_guard <= r_guard + 2'd1;
            end
        end
    end

    assign w_btn_rise   = r_sync2 & ~r_btn_prev;
    assign w_red_rise   = red_light & ~r_red_q;
    assign w_check_en   = (r_guard == c_GUARD_DONE);
    assign w_lights_bad = ({red_light, yellow_light, green_light} != 3'b100) &&
                          ({red_light, yellow_light, green_light} != 3'b010) &&
                          ({red_light, yellow_light, green_light} != 3'b001);

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_timer;
    logic [3:0] w_timer_nxt;
    logic       r_pending;
    logic       w_pending_nxt;
    logic       r_flash_dw;
    logic       w_flash_dw_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_timer    <= 4'd0;
            r_pending  <= 1'b0;
            r_flash_dw <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pending_nxt;
            r_flash_dw <= w_flash_dw_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_pending_nxt  = r_pending;
        w_flash_dw_nxt = r_flash_dw;

        case (r_state)
            S_IDLE: begin
                if ((r_pending || w_btn_rise) && w_red_rise) begin
                    w_state_nxt   = S_WALK;
                    w_timer_nxt   = c_WALK_LOAD;
                    w_pending_nxt = 1'b0;
                end else if (w_btn_rise) begin
                    w_pending_nxt = 1'b1;
                end
            end

            S_WALK: begin
                // Presses during WALK are already being served and are dropped.
                if (!red_light) begin
                    w_state_nxt   = S_IDLE;
                    w_timer_nxt   = 4'd0;
                    w_pending_nxt = 1'b1;
                end else if (r_timer == 4'd0) begin
                    w_state_nxt    = S_FLASH;
                    w_timer_nxt    = c_FLASH_LOAD;
                    w_flash_dw_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 4'd1;
                end
            end

            S_FLASH: begin
                if (!red_light) begin
                    w_state_nxt   = S_IDLE;
                    w_timer_nxt   = 4'd0;
                    w_pending_nxt = 1'b1;
                end else begin
                    if (w_btn_rise) begin
                        w_pending_nxt = 1'b1;
                    end
                    if (r_timer == 4'd0) begin
                        w_state_nxt    = S_IDLE;
                        w_flash_dw_nxt = 1'b1;
                    end else begin
                        w_timer_nxt    = r_timer - 4'd1;
                        w_flash_dw_nxt = ~r_flash_dw;
                    end
                end
            end

            S_FAULT: begin
                w_state_nxt   = S_FAULT;
                w_pending_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = S_FAULT;
            end
        endcase

        // Light-pattern fault wins over every other transition.
        if (w_check_en && w_lights_bad) begin
            w_state_nxt    = S_FAULT;
            w_timer_nxt    = 4'd0;
            w_pending_nxt  = 1'b0;
            w_flash_dw_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        flash     = 1'b0;
        countdown = 4'd0;
        fault     = 1'b0;
        ped_wait  = r_pending;

        case (r_state)
            S_WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
                countdown = r_timer;
            end
            S_FLASH: begin
                flash     = 1'b1;
                dont_walk = r_flash_dw;
                countdown = r_timer;
            end
            S_FAULT: begin
                fault    = 1'b1;
                ped_wait = 1'b0;
            end
            default: begin
                dont_walk = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pedestrian_signal_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pedestrian_signal_controller
// Brief    : Directed, table-driven bench for pedestrian_signal_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pedestrian_signal_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ped_button = 1'b0;
    logic       red_light = 1'b1;
    logic       yellow_light = 1'b0;
    logic       green_light = 1'b0;
    logic       walk;
    logic       dont_walk;
    logic       flash;
    logic       ped_wait;
    logic [3:0] countdown;
    logic       fault;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [2:0] L_R  = 3'b100;
    localparam logic [2:0] L_Y  = 3'b010;
    localparam logic [2:0] L_G  = 3'b001;
    localparam logic [2:0] L_RG = 3'b101;

    localparam logic [8:0] M_ALL   = 9'h1FF;
    localparam logic [8:0] M_FAULT = 9'h1DF;

    pedestrian_signal_controller #(
        .WALK_TIME (4'd6),
        .FLASH_TIME(4'd3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ped_button  (ped_button),
        .red_light   (red_light),
        .yellow_light(yellow_light),
        .green_light (green_light),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .flash       (flash),
        .ped_wait    (ped_wait),
        .countdown   (countdown),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Expected output vector: {walk, dont_walk, flash, ped_wait, countdown, fault}
    function automatic logic [8:0] e_idle(input logic w);
        return {1'b0, 1'b1, 1'b0, w, 4'd0, 1'b0};
    endfunction

    function automatic logic [8:0] e_walk(input logic [3:0] cd);
        return {1'b1, 1'b0, 1'b0, 1'b0, cd, 1'b0};
    endfunction

    function automatic logic [8:0] e_flash(input logic dw, input logic w, input logic [3:0] cd);
        return {1'b0, dw, 1'b1, w, cd, 1'b0};
    endfunction

    function automatic logic [8:0] e_fault();
        return {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};
    endfunction

    task automatic check(input string name, input logic [8:0] exp, input logic [8:0] mask);
        logic [8:0] act;
        act = {walk, dont_walk, flash, ped_wait, countdown, fault};
        n_total++;
        if ((act & mask) === (exp & mask)) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got walk=%b dw=%b flash=%b wait=%b cd=%0d fault=%b, want walk=%b dw=%b flash=%b wait=%b cd=%0d fault=%b (mask %b)",
                     name, $time, act[8], act[7], act[6], act[5], act[4:1], act[0],
                     exp[8], exp[7], exp[6], exp[5], exp[4:1], exp[0], mask);
        end
    endtask

    task automatic step(input logic [2:0] l, input logic b, input string name,
                        input logic [8:0] exp, input logic [8:0] mask);
        {red_light, yellow_light, green_light} = l;
        ped_button = b;
        @(posedge clk);
        #1;
        check(name, exp, mask);
    endtask

    task automatic run(input logic [2:0] l, input int n, input string name, input logic [8:0] exp);
        for (int i = 0; i < n; i++) begin
            step(l, 1'b0, name, exp, M_ALL);
        end
    endtask

    typedef struct {
        logic [2:0] l;
        logic       b;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[20];

    initial begin
        // Press in green, served at the next red rise.
        tbl[0]  = '{L_G, 1'b1, e_idle(1'b0)};
        tbl[1]  = '{L_G, 1'b1, e_idle(1'b0)};
        tbl[2]  = '{L_G, 1'b0, e_idle(1'b1)};
        tbl[3]  = '{L_Y, 1'b0, e_idle(1'b1)};
        tbl[4]  = '{L_Y, 1'b0, e_idle(1'b1)};
        tbl[5]  = '{L_Y, 1'b0, e_idle(1'b1)};
        tbl[6]  = '{L_R, 1'b0, e_walk(4'd5)};
        tbl[7]  = '{L_R, 1'b0, e_walk(4'd4)};
        tbl[8]  = '{L_R, 1'b0, e_walk(4'd3)};
        tbl[9]  = '{L_R, 1'b0, e_walk(4'd2)};
        tbl[10] = '{L_R, 1'b0, e_walk(4'd1)};
        tbl[11] = '{L_R, 1'b0, e_walk(4'd0)};
        tbl[12] = '{L_R, 1'b0, e_flash(1'b1, 1'b0, 4'd2)};
        tbl[13] = '{L_R, 1'b0, e_flash(1'b0, 1'b0, 4'd1)};
        tbl[14] = '{L_R, 1'b0, e_flash(1'b1, 1'b0, 4'd0)};
        tbl[15] = '{L_R, 1'b0, e_idle(1'b0)};
        tbl[16] = '{L_R, 1'b0, e_idle(1'b0)};
        tbl[17] = '{L_R, 1'b0, e_idle(1'b0)};
        tbl[18] = '{L_R, 1'b0, e_idle(1'b0)};
        tbl[19] = '{L_R, 1'b0, e_idle(1'b0)};

        // Reset values while reset is held
        #1;
        check("reset_async", e_idle(1'b0), M_ALL);
        @(posedge clk);
        #1;
        check("reset_held", e_idle(1'b0), M_ALL);
        reset = 1'b1;

        // Full light loop with no press
        run(L_R, 12, "idle_red", e_idle(1'b0));
        run(L_Y, 3, "idle_yel", e_idle(1'b0));
        run(L_G, 10, "idle_grn", e_idle(1'b0));
        run(L_Y, 3, "idle_yel2", e_idle(1'b0));
        run(L_R, 12, "idle_red2", e_idle(1'b0));
        run(L_Y, 3, "idle_yel3", e_idle(1'b0));
        run(L_G, 5, "idle_grn2", e_idle(1'b0));

        // Table: press in green, full WALK + FLASH cycle
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].l, tbl[i].b, $sformatf("tbl[%0d]", i), tbl[i].exp, M_ALL);
        end

        // Press shortly after red rise waits for the following red
        run(L_Y, 3, "t3_yel", e_idle(1'b0));
        run(L_G, 8, "t3_grn", e_idle(1'b0));
        run(L_Y, 3, "t3_yel2", e_idle(1'b0));
        step(L_R, 1'b0, "t3_red_rise", e_idle(1'b0), M_ALL);
        step(L_R, 1'b1, "t3_press1", e_idle(1'b0), M_ALL);
        step(L_R, 1'b1, "t3_press2", e_idle(1'b0), M_ALL);
        step(L_R, 1'b0, "t3_wait_set", e_idle(1'b1), M_ALL);
        run(L_R, 10, "t3_no_mid_red_walk", e_idle(1'b1));
        run(L_Y, 3, "t3_yel3", e_idle(1'b1));
        run(L_G, 8, "t3_grn2", e_idle(1'b1));
        run(L_Y, 3, "t3_yel4", e_idle(1'b1));

        // Served walk; press during WALK ignored, press during FLASH latched
        step(L_R, 1'b1, "t4_w1", e_walk(4'd5), M_ALL);
        step(L_R, 1'b1, "t4_w2", e_walk(4'd4), M_ALL);
        step(L_R, 1'b0, "t4_w3_ignore", e_walk(4'd3), M_ALL);
        step(L_R, 1'b0, "t4_w4", e_walk(4'd2), M_ALL);
        step(L_R, 1'b0, "t4_w5", e_walk(4'd1), M_ALL);
        step(L_R, 1'b1, "t4_w6", e_walk(4'd0), M_ALL);
        step(L_R, 1'b1, "t4_f1", e_flash(1'b1, 1'b0, 4'd2), M_ALL);
        step(L_R, 1'b0, "t4_f2_latch", e_flash(1'b0, 1'b1, 4'd1), M_ALL);
        step(L_R, 1'b0, "t4_f3", e_flash(1'b1, 1'b1, 4'd0), M_ALL);
        run(L_R, 5, "t4_idle_pending", e_idle(1'b1));
        run(L_Y, 3, "t4_yel", e_idle(1'b1));
        run(L_G, 8, "t4_grn", e_idle(1'b1));
        run(L_Y, 3, "t4_yel2", e_idle(1'b1));

        // Red drops during WALK: abort and re-queue
        step(L_R, 1'b0, "t5_w1", e_walk(4'd5), M_ALL);
        step(L_R, 1'b0, "t5_w2", e_walk(4'd4), M_ALL);
        step(L_R, 1'b0, "t5_w3", e_walk(4'd3), M_ALL);
        step(L_Y, 1'b0, "t5_abort", e_idle(1'b1), M_ALL);
        run(L_Y, 2, "t5_yel", e_idle(1'b1));
        run(L_G, 8, "t5_grn", e_idle(1'b1));
        run(L_Y, 3, "t5_yel2", e_idle(1'b1));
        step(L_R, 1'b0, "t5_reserve_w1", e_walk(4'd5), M_ALL);
        step(L_R, 1'b0, "t5_reserve_w2", e_walk(4'd4), M_ALL);

        // Reset asserted mid-WALK
        reset = 1'b0;
        #1;
        check("t6_reset_mid_walk", e_idle(1'b0), M_ALL);
        @(posedge clk);
        #1;
        check("t6_reset_held", e_idle(1'b0), M_ALL);
        reset = 1'b1;

        // Guard masks the first two edges, then a bad pattern latches FAULT
        step(L_RG, 1'b0, "t6_guard1", e_idle(1'b0), M_ALL);
        step(L_RG, 1'b0, "t6_guard2", e_idle(1'b0), M_ALL);
        step(L_R, 1'b0, "t6_post_guard", e_idle(1'b0), M_ALL);
        step(L_RG, 1'b0, "t6_fault_set", e_fault(), M_FAULT);
        step(L_R, 1'b1, "t6_fault_hold1", e_fault(), M_FAULT);
        step(L_R, 1'b1, "t6_fault_hold2", e_fault(), M_FAULT);
        step(L_Y, 1'b0, "t6_fault_hold3", e_fault(), M_FAULT);
        step(L_R, 1'b0, "t6_fault_red_rise", e_fault(), M_FAULT);
        step(L_R, 1'b0, "t6_fault_hold4", e_fault(), M_FAULT);

        reset = 1'b0;
        #1;
        check("t6_fault_cleared", e_idle(1'b0), M_ALL);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(L_R, 1'b0, "t6_after_reset", e_idle(1'b0), M_ALL);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
